// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access-type codes and a
// legality helper used by the controller and its lane-alignment datapath.
package dm_ctrl_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  // Codes 5..7 are unassigned and must be reported as errors.
  function automatic logic dm_type_legal(input logic [2:0] t);
    return t <= 3'd4;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering: store data replication, per-byte write
// enables, load extraction with sign/zero extension, and misalignment detect.
module dm_lane_align
  import dm_ctrl_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    rbyte      = rdata_raw_i[{lane_i, 3'b000} +: 8];
    rhalf      = rdata_raw_i[{lane_i[1], 4'b0000} +: 16];

    case (type_i)
      DM_WORD: begin
        be_o       = 4'b1111;
        rdata_o    = rdata_raw_i;
        misalign_o = (lane_i != 2'b00);
      end
      DM_HALF, DM_HALF_U: begin
        be_o       = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (type_i == DM_HALF) ? {{16{rhalf[15]}}, rhalf} : {16'h0000, rhalf};
        misalign_o = lane_i[0];
      end
      DM_BYTE, DM_BYTE_U: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (type_i == DM_BYTE) ? {{24{rbyte[7]}}, rbyte} : {24'h000000, rbyte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data memory controller: valid/ready request port, optional wait states,
// byte-lane-correct sub-word access and a one-cycle response pulse.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IdxW     = $clog2(DEPTH_WORDS);
  localparam bit         NoWait   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WaitLoad = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        type_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [2:0]        c_type;
  logic [31:0]       c_wdata;
  logic [IdxW-1:0]   c_idx;
  logic              range_err;
  logic              c_err;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              lane_misalign;

  assign accept = req_valid & req_ready_q;

  // Without wait states the RESP-entry edge is the accept edge itself, so the
  // commit datapath must look at the live request rather than the captured copy.
  assign commit  = NoWait ? (state_q == ST_IDLE && accept)
                          : (state_q == ST_WAIT && cnt_q == 4'd0);
  assign c_we    = NoWait ? req_we    : we_q;
  assign c_addr  = NoWait ? req_addr  : addr_q;
  assign c_type  = NoWait ? req_type  : type_q;
  assign c_wdata = NoWait ? req_wdata : wdata_q;

  assign c_idx     = c_addr[IdxW+1:2];
  assign range_err = (c_addr >> (IdxW + 2)) != '0;
  assign c_err     = lane_misalign | range_err | ~dm_type_legal(c_type);

  dm_lane_align u_lane_align (
    .type_i      (c_type),
    .lane_i      (c_addr[1:0]),
    .wdata_i     (c_wdata),
    .rdata_raw_i (mem_q[c_idx]),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata),
    .misalign_o  (lane_misalign)
  );

  // NOTE: the RAM has no reset branch; clearing it would defeat block-RAM inference.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem_q[c_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      type_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;

      if (commit) begin
        rsp_err_q   <= c_err;
        rsp_rdata_q <= (c_we || c_err) ? 32'h0 : lane_rdata;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            type_q      <= req_type;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (NoWait) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WaitLoad;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b1;
          req_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: three instances (0, 2 and 3 wait states)
// exercised with directed steps and a random stream against a byte-array model.
module tb_dm_ctrl;

  localparam int DEPTH = 64;
  localparam int NDUT  = 3;

  logic clk = 1'b0;
  logic rstn;

  logic [NDUT-1:0]        req_valid;
  logic [NDUT-1:0]        req_ready;
  logic [NDUT-1:0]        req_we;
  logic [NDUT-1:0][31:0]  req_addr;
  logic [NDUT-1:0][2:0]   req_type;
  logic [NDUT-1:0][31:0]  req_wdata;
  logic [NDUT-1:0]        rsp_valid;
  logic [NDUT-1:0][31:0]  rsp_rdata;
  logic [NDUT-1:0]        rsp_err;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dm_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (32),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_type  (req_type[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference memory as plain bytes, one bank per instance.
  logic [7:0] mm [NDUT][4*DEPTH];

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected result of one access, computed from access size and byte addressing.
  function automatic void model(input int d, input logic we, input logic [31:0] addr,
                                input logic [2:0] t, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int size;
    bit sgn;
    logic [31:0] v;
    int base;
    size = 0;
    sgn  = 0;
    case (t)
      3'd0: size = 4;
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 2;
      3'd3: begin size = 1; sgn = 1; end
      3'd4: size = 1;
      default: size = 0;
    endcase
    err = (size == 0) || (addr >= 32'(4 * DEPTH)) || ((addr % 32'(size)) != 0);
    rd  = '0;
    if (!err) begin
      base = int'(addr[7:0]);
      if (we) begin
        for (int i = 0; i < size; i++) mm[d][base + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mm[d][base + i];
        if (sgn && v[8*size-1]) begin
          for (int b = 8 * size; b < 32; b++) v[b] = 1'b1;
        end
        rd = v;
      end
    end
  endfunction

  // One complete request: handshake, latency, pulse width and model comparison.
  task automatic xfer(input int d, input logic we, input logic [31:0] addr,
                      input logic [2:0] t, input logic [31:0] wd, input string tag,
                      output logic [31:0] rd, output logic err);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          cyc;
    bit          got;
    bit          ready_bad;
    model(d, we, addr, t, wd, exp_rd, exp_err);
    @(negedge clk);
    check({tag, " idle"}, {30'b0, rsp_valid[d], req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_type[d]  = t;
    req_wdata[d] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = $urandom;
    req_type[d]  = 3'($urandom);
    req_wdata[d] = $urandom;
    cyc       = 1;
    got       = 0;
    ready_bad = 0;
    while (cyc <= 40) begin
      if (rsp_valid[d] === 1'b1) begin
        got = 1;
        break;
      end
      if (req_ready[d] !== 1'b0) ready_bad = 1;
      @(negedge clk);
      cyc++;
    end
    check({tag, " rsp_seen"}, {31'b0, got}, 32'd1);
    check({tag, " latency"}, cyc, 32'(2 + wait_of(d)));
    check({tag, " ready_low"}, {31'b0, ready_bad}, 32'd0);
    rd  = rsp_rdata[d];
    err = rsp_err[d];
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, " pulse"}, {31'b0, rsp_valid[d]}, 32'd0);
  endtask

  // req_valid held high: accepts every 2+W cycles, responses 2+W negedges after accept.
  task automatic burst(input int d, input string tag);
    int per;
    per = 2 + wait_of(d);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b0;
    req_addr[d]  = 32'h0;
    req_type[d]  = 3'd0;
    for (int j = 0; j < 12; j++) begin
      check($sformatf("%s ready[%0d]", tag, j), {31'b0, req_ready[d]}, {31'b0, (j % per) == 0});
      check($sformatf("%s rsp[%0d]", tag, j), {31'b0, rsp_valid[d]},
            {31'b0, (j > 0) && ((j % per) == 0)});
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [2:0]  t;
    int          r;
    bit          seen;

    rstn      = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_type  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset%0d ctl", d), {29'b0, req_ready[d], rsp_valid[d], rsp_err[d]}, 32'd4);
      check($sformatf("reset%0d rdata", d), rsp_rdata[d], 32'h0);
    end
    rstn = 1'b1;

    // Reset during WAIT drops the in-flight store.
    xfer(2, 1'b1, 32'h40, 3'd0, 32'h1234_5678, "t1 prewrite", rd, er);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h40;
    req_type[2]  = 3'd0;
    req_wdata[2] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("t1 reset ctl", {29'b0, req_ready[2], rsp_valid[2], rsp_err[2]}, 32'd4);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid[2] === 1'b1) seen = 1;
    end
    check("t1 no_rsp", {31'b0, seen}, 32'd0);
    xfer(2, 1'b0, 32'h40, 3'd0, 32'h0, "t1 reload", rd, er);
    check("t1 prior", rd, 32'h1234_5678);

    // Sub-word loads with sign/zero extension.
    xfer(0, 1'b1, 32'h10, 3'd0, 32'h8040_C0FF, "t2 sw", rd, er);
    xfer(0, 1'b0, 32'h10, 3'd3, 32'h0, "t2 lb", rd, er);
    check("t2 lb val", rd, 32'hFFFF_FFFF);
    xfer(0, 1'b0, 32'h11, 3'd4, 32'h0, "t2 lbu", rd, er);
    check("t2 lbu val", rd, 32'h0000_00C0);
    xfer(0, 1'b0, 32'h12, 3'd1, 32'h0, "t2 lh", rd, er);
    check("t2 lh val", rd, 32'hFFFF_8040);
    xfer(0, 1'b0, 32'h12, 3'd2, 32'h0, "t2 lhu", rd, er);
    check("t2 lhu val", rd, 32'h0000_8040);

    // Partial stores leave other lanes untouched.
    xfer(0, 1'b1, 32'h20, 3'd0, 32'h1122_3344, "t3 sw", rd, er);
    xfer(0, 1'b1, 32'h21, 3'd3, 32'h0000_00AA, "t3 sb", rd, er);
    xfer(0, 1'b0, 32'h20, 3'd0, 32'h0, "t3 lw1", rd, er);
    check("t3 lw1 val", rd, 32'h1122_AA44);
    xfer(0, 1'b1, 32'h22, 3'd1, 32'h0000_BEEF, "t3 sh", rd, er);
    xfer(0, 1'b0, 32'h20, 3'd0, 32'h0, "t3 lw2", rd, er);
    check("t3 lw2 val", rd, 32'hBEEF_AA44);

    // Error cases: no write, zero data, err flag.
    xfer(0, 1'b1, 32'h00, 3'd0, 32'hCAFE_F00D, "t4 pre0", rd, er);
    xfer(0, 1'b1, 32'h04, 3'd0, 32'h0102_0304, "t4 pre4", rd, er);
    xfer(0, 1'b0, 32'h02, 3'd0, 32'h0, "t4 lw_mis", rd, er);
    check("t4 lw_mis flag", {31'b0, er}, 32'd1);
    xfer(0, 1'b1, 32'h03, 3'd1, 32'h0000_FFFF, "t4 sh_mis", rd, er);
    check("t4 sh_mis flag", {31'b0, er}, 32'd1);
    xfer(0, 1'b1, 32'h04, 3'd7, 32'hFFFF_FFFF, "t4 badtype", rd, er);
    check("t4 badtype flag", {31'b0, er}, 32'd1);
    xfer(0, 1'b0, 32'(4 * DEPTH), 3'd0, 32'h0, "t4 range", rd, er);
    check("t4 range flag", {31'b0, er}, 32'd1);
    check("t4 range rdata", rd, 32'h0);
    xfer(0, 1'b0, 32'h00, 3'd0, 32'h0, "t4 chk0", rd, er);
    check("t4 chk0 val", rd, 32'hCAFE_F00D);
    xfer(0, 1'b0, 32'h04, 3'd0, 32'h0, "t4 chk4", rd, er);
    check("t4 chk4 val", rd, 32'h0102_0304);

    // Random stream against the byte-array model.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < DEPTH; w++) begin
        xfer(d, 1'b1, 32'(4 * w), 3'd0, $urandom, $sformatf("init%0d.%0d", d, w), rd, er);
      end
      for (int i = 0; i < 250; i++) begin
        r = $urandom_range(0, 15);
        t = (r < 14) ? 3'(r % 5) : 3'(5 + (r % 3));
        r = $urandom_range(0, 19);
        if (r == 0)      a = 32'h100 + 32'($urandom_range(0, 255));
        else if (r == 1) a = $urandom | 32'h8000_0000;
        else             a = 32'($urandom_range(0, 4 * DEPTH - 1));
        if (r >= 8) begin
          if (t == 3'd0)                   a[1:0] = 2'b00;
          else if (t == 3'd1 || t == 3'd2) a[0]   = 1'b0;
        end
        xfer(d, 1'($urandom), a, t, $urandom, $sformatf("rnd%0d.%0d", d, i), rd, er);
      end
    end

    // Throughput and ready behaviour with req_valid held high.
    burst(0, "t5 w0");
    burst(1, "t5 w2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
